// File: rtl/ripple_adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Holds the default width and a reference add used only by checkers.
package ripple_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Exact (w+1)-bit result of a+b+cin for operands of width w (1..64).
    function automatic logic [64:0] ref_add(
        input int unsigned w,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        cin
    );
        logic [64:0] mask;
        logic [64:0] res;
        mask = (65'd1 << w) - 65'd1;
        res  = {1'b0, a & mask[63:0]}
             + {1'b0, b & mask[63:0]}
             + 65'(cin);
        return res & ((mask << 1) | 65'd1);
    endfunction

endpackage

// File: rtl/ripple_adder_full_adder.sv
// One-bit full adder cell used as the ripple-carry chain element.
// Ports: a, b, cin in; s (sum bit), cout (carry out) out. Combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/ripple_adder.sv
// Registered ripple-carry adder: {carry_out,sum} <= a + b + carry_in.
// Ports: clk, rst_n (sync, active-low), in_valid, a, b, carry_in in;
// out_valid, sum, carry_out out. Macro RIPPLE_ADDER_OVERFLOW_EN adds
// output overflow (registered signed two's-complement overflow).
module ripple_adder
    import ripple_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    assign w_c[0] = carry_in;

    // Carry ripples bit-serially; each cell feeds the next one's cin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .s    (w_s[i]),
            .cout (w_c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            sum       <= w_s;
            carry_out <= w_c[WIDTH];
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef RIPPLE_ADDER_OVERFLOW_EN
    // Carries into and out of the sign bit disagree on signed overflow;
    // for WIDTH=1 the carry into the sign bit is carry_in itself.
    logic w_ovf;

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid) begin
            overflow <= w_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder at WIDTH=4 and WIDTH=16.
// Directed, exhaustive and $urandom stimulus against arithmetic model.
module tb_ripple_adder;
    import ripple_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv4, ci4;
    logic [3:0]  a4, b4;
    logic        ov4, co4;
    logic [3:0]  s4;

    logic        iv16, ci16;
    logic [15:0] a16, b16;
    logic        ov16, co16;
    logic [15:0] s16;

`ifdef RIPPLE_ADDER_OVERFLOW_EN
    logic        of4, of16;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  last4;
    logic [16:0] last16;

    always #5 clk = ~clk;

    ripple_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .a         (a4),
        .b         (b4),
        .carry_in  (ci4),
        .out_valid (ov4),
        .sum       (s4),
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        .overflow  (of4),
`endif
        .carry_out (co4)
    );

    ripple_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .a         (a16),
        .b         (b16),
        .carry_in  (ci16),
        .out_valid (ov16),
        .sum       (s16),
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        .overflow  (of16),
`endif
        .carry_out (co16)
    );

    task automatic chk(input string tag, input logic [64:0] got,
                       input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are
    // sampled at the same point, one full edge after capture.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Signed overflow from integer arithmetic on sign-extended operands.
    function automatic logic sovf(input int w, input longint ua,
                                  input longint ub, input int c);
        longint sa, sb, r, lim;
        lim = longint'(1) << (w - 1);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sb  = (ub >= lim) ? ub - 2 * lim : ub;
        r   = sa + sb + longint'(c);
        return (r >= lim) || (r < -lim);
    endfunction

    task automatic add4(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic c);
        logic [64:0] e;
        a4 = a; b4 = b; ci4 = c; iv4 = 1'b1;
        e  = ref_add(4, 64'(a), 64'(b), c);
        step();
        chk({tag, "_v"}, 65'(ov4), 65'd1);
        chk({tag, "_r"}, 65'({co4, s4}), e);
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        chk({tag, "_o"}, 65'(of4), 65'(sovf(4, longint'(a),
                                            longint'(b), int'(c))));
`endif
        last4 = e[4:0];
    endtask

    task automatic add16(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        logic [64:0] e;
        a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
        e   = ref_add(16, 64'(a), 64'(b), c);
        step();
        chk({tag, "_v"}, 65'(ov16), 65'd1);
        chk({tag, "_r"}, 65'({co16, s16}), e);
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        chk({tag, "_o"}, 65'(of16), 65'(sovf(16, longint'(a),
                                             longint'(b), int'(c))));
`endif
        last16 = e[16:0];
    endtask

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;

        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_v4", 65'(ov4), 65'd0);
            chk("rst_r4", 65'({co4, s4}), 65'd0);
            chk("rst_v16", 65'(ov16), 65'd0);
            chk("rst_r16", 65'({co16, s16}), 65'd0);
`ifdef RIPPLE_ADDER_OVERFLOW_EN
            chk("rst_o4", 65'(of4), 65'd0);
`endif
        end

        rst_n = 1'b1; iv4 = 1'b0; iv16 = 1'b0;
        step();
        chk("idle_v4", 65'(ov4), 65'd0);
        chk("idle_r4", 65'({co4, s4}), 65'd0);

        add4("basic", 4'b1001, 4'b1011, 1'b0);
        chk("basic_k", 65'({co4, s4}), 65'h14);
        add4("cin1", 4'b1111, 4'b1000, 1'b1);
        chk("cin1_k", 65'({co4, s4}), 65'h18);
        add4("cin2", 4'b0011, 4'b0100, 1'b1);
        chk("cin2_k", 65'({co4, s4}), 65'h08);
        add4("ripple", 4'b1111, 4'b0000, 1'b1);
        chk("ripple_k", 65'({co4, s4}), 65'h10);
        add4("zero", 4'b0000, 4'b0000, 1'b0);
        add4("max", 4'b1111, 4'b1111, 1'b1);
        chk("max_k", 65'({co4, s4}), 65'h1F);

        add4("b2b0", 4'h3, 4'h5, 1'b0);
        add4("b2b1", 4'hA, 4'h9, 1'b1);
        add4("b2b2", 4'h6, 4'hC, 1'b0);
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_v", 65'(ov4), 65'd0);
            chk("hold_r", 65'({co4, s4}), 65'(last4));
        end

        add4("ovf_pos", 4'b0111, 4'b0001, 1'b0);
        add4("ovf_neg", 4'b1000, 4'b1000, 1'b0);
        chk("ovf_neg_k", 65'({co4, s4}), 65'h10);

        add4("pre_rst", 4'h7, 4'h7, 1'b1);
        rst_n = 1'b0; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        step();
        chk("midrst_v", 65'(ov4), 65'd0);
        chk("midrst_r", 65'({co4, s4}), 65'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            add4("exh", v[3:0], v[7:4], v[8]);
        end
        iv4 = 1'b0;

        add16("w16_max", 16'hFFFF, 16'hFFFF, 1'b1);
        add16("w16_rip", 16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 400; i++) begin
            add16("rnd16", 16'($urandom), 16'($urandom),
                  1'($urandom_range(1, 0)));
        end
        iv16 = 1'b0;
        step();
        chk("w16_hold_v", 65'(ov16), 65'd0);
        chk("w16_hold_r", 65'({co16, s16}), 65'(last16));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
